// File: rtl/breakout_pkg.sv
// Shared state encoding and default timing constants for the breakout
// game-flow controller and its key conditioners.
package breakout_pkg;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      IDLE   = 2'd1,
      PLAY   = 2'd2,
      RESULT = 2'd3
   } ctrl_state_t;

   localparam int DEF_DEB_CYCLES  = 500000;    // 20 ms at 25 MHz
   localparam int DEF_RESULT_HOLD = 50000000;  // 2 s at 25 MHz
   localparam int DEF_RST_CYCLES  = 16;

   // Width of a counter covering 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> pressed-high debounced level,
// plus a one-cycle pulse on the cycle after a released->pressed commit.
module key_debounce
   import breakout_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic level,
   output logic rise_pulse
);

   localparam int            CW       = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic          pressed;
   logic [CW-1:0] cnt;
   logic          commit;

   // Synchroniser resets to the released level so nothing commits out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], key_n};
      end
   end

   assign pressed = ~sync[1];
   assign commit  = (pressed != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level      <= 1'b0;
         cnt        <= '0;
         rise_pulse <= 1'b0;
      end else begin
         rise_pulse <= commit & pressed;
         if ((pressed == level) || commit) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (commit) begin
            level <= pressed;
         end
      end
   end

endmodule

// File: rtl/breakout_ctrl.sv
// Game-flow controller for the breakout core: conditions the S/D/START keys
// and sequences CLEAR -> IDLE -> PLAY -> RESULT with a scoped core reset.
module breakout_ctrl
   import breakout_pkg::*;
#(
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int RESULT_HOLD = DEF_RESULT_HOLD,
   parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       key_s_n,
   input  logic       key_d_n,
   input  logic       key_start_n,
   input  logic       game_win,
   input  logic       game_lose,
   output logic       left_btn,
   output logic       right_btn,
   output logic       game_active,
   output logic       game_rst_n,
   output logic [1:0] ctrl_state,
   output logic       last_win
);

   localparam int            RW        = cnt_width(RST_CYCLES);
   localparam int            HW        = cnt_width(RESULT_HOLD);
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_HOLD - 1);

   ctrl_state_t   state;
   ctrl_state_t   state_next;
   logic [RW-1:0] rst_cnt;
   logic [RW-1:0] rst_cnt_next;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_cnt_next;
   logic          last_win_next;

   logic s_level;
   logic d_level;
   logic start_pulse;
   logic unused_s_rise;
   logic unused_d_rise;
   logic unused_start_level;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_s (
      .clk        (vga_clk),
      .rst_n      (sys_rst_n),
      .key_n      (key_s_n),
      .level      (s_level),
      .rise_pulse (unused_s_rise)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_d (
      .clk        (vga_clk),
      .rst_n      (sys_rst_n),
      .key_n      (key_d_n),
      .level      (d_level),
      .rise_pulse (unused_d_rise)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
      .clk        (vga_clk),
      .rst_n      (sys_rst_n),
      .key_n      (key_start_n),
      .level      (unused_start_level),
      .rise_pulse (start_pulse)
   );

   // Counters default to zero so every state entry starts them fresh.
   always_comb begin
      state_next    = state;
      rst_cnt_next  = '0;
      hold_cnt_next = '0;
      last_win_next = last_win;
      case (state)
         CLEAR: begin
            if (rst_cnt == RST_LAST) begin
               state_next = IDLE;
            end else begin
               rst_cnt_next = rst_cnt + RW'(1);
            end
         end
         IDLE: begin
            if (start_pulse) begin
               state_next = PLAY;
            end
         end
         PLAY: begin
            if (game_win) begin
               state_next    = RESULT;
               last_win_next = 1'b1;
            end else if (game_lose) begin
               state_next    = RESULT;
               last_win_next = 1'b0;
            end
         end
         RESULT: begin
            if (hold_cnt != HOLD_LAST) begin
               hold_cnt_next = hold_cnt + HW'(1);
            end else if (start_pulse) begin
               state_next = CLEAR;
            end else begin
               hold_cnt_next = hold_cnt;
            end
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change with the state.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= CLEAR;
         rst_cnt     <= '0;
         hold_cnt    <= '0;
         last_win    <= 1'b0;
         game_rst_n  <= 1'b0;
         game_active <= 1'b0;
         left_btn    <= 1'b0;
         right_btn   <= 1'b0;
      end else begin
         state       <= state_next;
         rst_cnt     <= rst_cnt_next;
         hold_cnt    <= hold_cnt_next;
         last_win    <= last_win_next;
         game_rst_n  <= (state_next != CLEAR);
         game_active <= (state_next == PLAY) || (state_next == RESULT);
         left_btn    <= (state_next == PLAY) && s_level;
         right_btn   <= (state_next == PLAY) && d_level;
      end
   end

   assign ctrl_state = state;

endmodule

// File: tb/tb_breakout_ctrl.sv
// Bench for breakout_ctrl: directed round sequences and random key/flag
// stimulus, every cycle compared against a cycle-level behavioural model.
module tb_breakout_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int RST  = 3;

   localparam int ST_CLEAR  = 0;
   localparam int ST_IDLE   = 1;
   localparam int ST_PLAY   = 2;
   localparam int ST_RESULT = 3;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n;
   logic       key_s_n;
   logic       key_d_n;
   logic       key_start_n;
   logic       game_win;
   logic       game_lose;
   logic       left_btn;
   logic       right_btn;
   logic       game_active;
   logic       game_rst_n;
   logic [1:0] ctrl_state;
   logic       last_win;

   int n_total = 0;
   int n_bad   = 0;

   breakout_ctrl #(
      .DEB_CYCLES  (DEB),
      .RESULT_HOLD (HOLD),
      .RST_CYCLES  (RST)
   ) dut (
      .vga_clk     (vga_clk),
      .sys_rst_n   (sys_rst_n),
      .key_s_n     (key_s_n),
      .key_d_n     (key_d_n),
      .key_start_n (key_start_n),
      .game_win    (game_win),
      .game_lose   (game_lose),
      .left_btn    (left_btn),
      .right_btn   (right_btn),
      .game_active (game_active),
      .game_rst_n  (game_rst_n),
      .ctrl_state  (ctrl_state),
      .last_win    (last_win)
   );

   always #5 vga_clk = ~vga_clk;

   // ---------------- reference model ----------------
   // Keys: a level flips once the last DEB synchronised samples (raw samples
   // taken 2..DEB+1 edges ago) all disagree with it.
   bit hist [3][DEB+2];
   bit m_lvl [3];
   bit m_pulse;
   int m_state;
   int m_n;
   bit m_last;
   bit m_left;
   bit m_right;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_lvl[k] = 1'b0;
         for (int i = 0; i < DEB + 2; i++) hist[k][i] = 1'b1;
      end
      m_pulse = 1'b0;
      m_state = ST_CLEAR;
      m_n     = 0;
      m_last  = 1'b0;
      m_left  = 1'b0;
      m_right = 1'b0;
   endtask

   task automatic model_step();
      bit raw [3];
      bit pulse_now;
      bit differ;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      raw[0]    = key_s_n;
      raw[1]    = key_d_n;
      raw[2]    = key_start_n;
      pulse_now = m_pulse;
      case (m_state)
         ST_CLEAR: begin
            if (m_n + 1 == RST) begin m_state = ST_IDLE; m_n = 0; end
            else m_n++;
         end
         ST_IDLE: if (pulse_now) m_state = ST_PLAY;
         ST_PLAY: begin
            if (game_win)       begin m_state = ST_RESULT; m_last = 1'b1; m_n = 0; end
            else if (game_lose) begin m_state = ST_RESULT; m_last = 1'b0; m_n = 0; end
         end
         default: begin
            if (pulse_now && m_n >= HOLD - 1) begin m_state = ST_CLEAR; m_n = 0; end
            else m_n++;
         end
      endcase
      m_left  = (m_state == ST_PLAY) && m_lvl[0];
      m_right = (m_state == ST_PLAY) && m_lvl[1];
      m_pulse = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = DEB + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
         hist[k][0] = raw[k];
         differ = 1'b1;
         for (int i = 2; i < DEB + 2; i++) begin
            if ((!hist[k][i]) == m_lvl[k]) differ = 1'b0;
         end
         if (differ) begin
            m_lvl[k] = !m_lvl[k];
            if (k == 2 && m_lvl[k]) m_pulse = 1'b1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("state",    32'(ctrl_state),  32'(m_state));
      chk("rst_n",    32'(game_rst_n),  32'(m_state != ST_CLEAR));
      chk("active",   32'(game_active), 32'(m_state >= ST_PLAY));
      chk("left",     32'(left_btn),    32'(m_left));
      chk("right",    32'(right_btn),   32'(m_right));
      chk("last_win", 32'(last_win),    32'(m_last));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge vga_clk);
      model_step();
      @(negedge vga_clk);
      check_outputs();
   endtask

   task automatic hold_keys(input bit s, input bit d, input bit st, input int n);
      key_s_n     = ~s;
      key_d_n     = ~d;
      key_start_n = ~st;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_flags(input bit win, input bit lose);
      game_win  = win;
      game_lose = lose;
      tick();
      game_win  = 1'b0;
      game_lose = 1'b0;
   endtask

   // Reset lands mid-phase so the asynchronous clear is seen before any edge.
   task automatic async_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_active", 32'(game_active), 32'd0);
      chk("arst_rst_n",  32'(game_rst_n),  32'd0);
      chk("arst_state",  32'(ctrl_state),  32'(ST_CLEAR));
      chk("arst_left",   32'(left_btn),    32'd0);
      @(negedge vga_clk);
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   int seg_rem [3];
   bit seg_prs [3];

   task automatic rand_inputs();
      for (int k = 0; k < 3; k++) begin
         if (seg_rem[k] == 0) begin
            seg_prs[k] = 1'($urandom_range(0, 1));
            seg_rem[k] = $urandom_range(1, 12);
         end
         seg_rem[k]--;
      end
      key_s_n     = ~seg_prs[0];
      key_d_n     = ~seg_prs[1];
      key_start_n = ~seg_prs[2];
      game_win    = ($urandom_range(0, 24) == 0);
      game_lose   = ($urandom_range(0, 24) == 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      sys_rst_n   = 1'b0;
      key_s_n     = 1'b1;
      key_d_n     = 1'b1;
      key_start_n = 1'b1;
      game_win    = 1'b0;
      game_lose   = 1'b0;
      for (int k = 0; k < 3; k++) begin seg_rem[k] = 0; seg_prs[k] = 1'b0; end
      model_reset();
      @(negedge vga_clk);
      check_outputs();
      tick();
      tick();
      sys_rst_n = 1'b1;

      // Core reset pulse after release, then IDLE.
      tick();
      chk("clr_rst_n_1", 32'(game_rst_n), 32'd0);
      tick();
      chk("clr_rst_n_2", 32'(game_rst_n), 32'd0);
      tick();
      chk("clr_to_idle", 32'(ctrl_state), 32'(ST_IDLE));
      hold_keys(0, 0, 0, 3);

      // START glitches are rejected, a stable press starts the round.
      hold_keys(0, 0, 1, 2);
      hold_keys(0, 0, 0, 2);
      hold_keys(0, 0, 1, 2);
      hold_keys(0, 0, 0, 2);
      chk("glitch_idle", 32'(ctrl_state), 32'(ST_IDLE));
      hold_keys(0, 0, 1, 10);
      chk("play_entry", 32'(game_active), 32'd1);
      hold_keys(0, 0, 0, 4);

      // S steers in PLAY, lose ends the round and masks the button.
      hold_keys(1, 0, 0, 8);
      chk("left_play", 32'(left_btn), 32'd1);
      pulse_flags(0, 1);
      chk("lose_state", 32'(ctrl_state), 32'(ST_RESULT));
      chk("lose_left",  32'(left_btn),   32'd0);

      // Early START is discarded; a later one restarts, held START stays idle.
      hold_keys(0, 0, 1, 6);
      hold_keys(0, 0, 0, 8);
      chk("early_start", 32'(ctrl_state), 32'(ST_RESULT));
      hold_keys(0, 0, 1, 14);
      chk("held_idle",   32'(ctrl_state), 32'(ST_IDLE));
      hold_keys(0, 0, 0, 8);
      chk("still_idle",  32'(ctrl_state), 32'(ST_IDLE));

      // Win beats lose when both rise together.
      hold_keys(0, 1, 1, 8);
      chk("right_play", 32'(right_btn), 32'd1);
      hold_keys(0, 0, 0, 2);
      pulse_flags(1, 1);
      chk("both_win", 32'(last_win), 32'd1);
      hold_keys(0, 0, 0, 12);
      hold_keys(0, 0, 1, 8);
      hold_keys(0, 0, 0, 6);
      hold_keys(0, 0, 1, 8);
      hold_keys(0, 0, 0, 2);
      chk("replay", 32'(ctrl_state), 32'(ST_PLAY));

      // Asynchronous reset mid-PLAY, then the reset sequence again.
      async_reset();
      tick();
      tick();
      chk("arst_clr", 32'(game_rst_n), 32'd0);
      tick();
      chk("arst_idle", 32'(ctrl_state), 32'(ST_IDLE));

      // Random keys and result flags, with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         rand_inputs();
         if ($urandom_range(0, 799) == 0) async_reset();
         else tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
